// File: rtl/cpmath_pkg.sv
// Shared types and constants for the CPU I/O blocks: output-buffer FSM states
// and the hex-to-seven-segment lookup used by the board displays.
package cpmath_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } saida_state_t;

    // Active-low segments, bit 0 = a ... bit 6 = g; entry 15 first.
    localparam logic [15:0][6:0] HEX7SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex7seg_f(input logic [3:0] nibble);
        return HEX7SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/saida_if.sv
// Bus between the CPU output strobe / user button and the output buffer,
// including the display-facing results.
interface saida_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] _input;
    logic              write;
    logic              switchNext;
    logic [DATA_W-1:0] output_;
    logic [55:0]       segments;
    logic              haveData;
    logic              full;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output _input, write, switchNext,
        input  output_, segments, haveData, full, overflow, count
    );

    modport slave (
        input  _input, write, switchNext,
        output output_, segments, haveData, full, overflow, count
    );
endinterface

// File: rtl/hex7seg.sv
// One hex digit to an active-low seven-segment pattern.
module hex7seg
    import cpmath_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7seg_f(nibble);

endmodule

// File: rtl/saida.sv
// CPU output buffer: in-order word queue whose head is shown on output_ and
// eight hex digits; a button rising edge steps to the next stored word.
module saida
    import cpmath_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    saida_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    saida_state_t      state_r, state_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_r, rd_nxt_s, wr_r, wr_nxt_s, rd_inc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] out_r, out_nxt_s;
    logic              prev_r, full_r, full_nxt_s, ovf_r, ovf_nxt_s;
    logic              have_r, have_nxt_s;
    logic              pop_req_s, pop_s, wr_acc_s;
    logic [55:0]       seg_s;

    assign pop_req_s = bus.switchNext & ~prev_r;
    assign pop_s     = pop_req_s & (state_r == SHOW);
    // A full queue can still take a word when the head leaves in the same cycle.
    assign wr_acc_s  = bus.write & (~full_r | pop_s);
    assign rd_inc_s  = rd_r + PTR_W'(1);

    // Next-state, pointer, occupancy and displayed-word logic.
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_r;
        rd_nxt_s    = rd_r;
        wr_nxt_s    = wr_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;

        case (state_r)
            EMPTY: begin
                if (bus.write) begin
                    state_nxt_s = SHOW;
                    out_nxt_s   = bus._input;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            SHOW: begin
                if (pop_s) begin
                    rd_nxt_s = rd_inc_s;
                    // With one word left, the next head is either today's write or nothing.
                    if (cnt_r == CNT_W'(1)) begin
                        if (wr_acc_s) begin
                            out_nxt_s = bus._input;
                        end else begin
                            out_nxt_s   = {DATA_W{1'b0}};
                            state_nxt_s = EMPTY;
                        end
                    end else begin
                        out_nxt_s = mem_r[rd_inc_s];
                    end
                end else begin
                    out_nxt_s = out_r;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
                out_nxt_s   = {DATA_W{1'b0}};
            end
        endcase

        if (wr_acc_s) begin
            wr_nxt_s = wr_r + PTR_W'(1);
        end else begin
            wr_nxt_s = wr_r;
        end

        if (bus.write && !wr_acc_s) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        case ({wr_acc_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    assign full_nxt_s = (cnt_nxt_s == CNT_W'(DEPTH));
    assign have_nxt_s = (state_nxt_s == SHOW);

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= EMPTY;
            rd_r    <= {PTR_W{1'b0}};
            wr_r    <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            out_r   <= {DATA_W{1'b0}};
            prev_r  <= 1'b0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            have_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rd_r    <= rd_nxt_s;
            wr_r    <= wr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= out_nxt_s;
            prev_r  <= bus.switchNext;
            full_r  <= full_nxt_s;
            ovf_r   <= ovf_nxt_s;
            have_r  <= have_nxt_s;
        end
    end

    // Queue storage; contents are irrelevant until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_r] <= bus._input;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_digit
        hex7seg u_hex7seg (
            .nibble (out_r[4*i +: 4]),
            .seg    (seg_s[7*i +: 7])
        );
    end

    assign bus.output_  = out_r;
    assign bus.segments = seg_s;
    assign bus.haveData = have_r;
    assign bus.full     = full_r;
    assign bus.overflow = ovf_r;
    assign bus.count    = cnt_r;

endmodule

// File: tb/tb_saida.sv
// Directed bench for saida with a queue scoreboard of the words that should be stored.
module tb_saida;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] sb_q [$];
    logic        m_prev = 1'b0;
    logic        m_ovf  = 1'b0;

    saida_if #(.DEPTH(16), .DATA_W(32)) bus ();

    saida #(.DEPTH(16), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] segs_of(input logic [31:0] w);
        logic [55:0] s;
        for (int i = 0; i < 8; i++) s[7*i +: 7] = seg7(w[4*i +: 4]);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model, then land 1 ns after the edge.
    task automatic cycle(input logic w, input logic [31:0] d, input logic sw);
        logic pop, acc;
        bus._input     = d;
        bus.write      = w;
        bus.switchNext = sw;
        pop    = sw & ~m_prev & (sb_q.size() > 0);
        m_prev = sw;
        acc    = w & ((sb_q.size() < 16) | pop);
        if (pop) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(d);
        if (w & ~acc) m_ovf = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] head;
        head = (sb_q.size() > 0) ? sb_q[0] : 32'h0;
        chk({tag, ".output"},   64'(bus.output_),  64'(head));
        chk({tag, ".count"},    64'(bus.count),    64'(sb_q.size()));
        chk({tag, ".haveData"}, 64'(bus.haveData), 64'(sb_q.size() > 0));
        chk({tag, ".full"},     64'(bus.full),     64'(sb_q.size() == 16));
        chk({tag, ".overflow"}, 64'(bus.overflow), 64'(m_ovf));
        chk({tag, ".segments"}, 64'(bus.segments), 64'(segs_of(head)));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        bus._input     = 32'h0;
        bus.write      = 1'b0;
        bus.switchNext = 1'b0;
        model_reset();

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_all("reset");
        cycle(1'b0, 32'h0, 1'b0);
        check_all("idle");

        // Order check
        cycle(1'b1, 32'h0000_0011, 1'b0);
        chk("first_write_latency", 64'(bus.output_), 64'h11);
        cycle(1'b1, 32'h0000_0022, 1'b0);
        cycle(1'b1, 32'h0000_0033, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check_all("three_writes");
        chk("count_is_3", 64'(bus.count), 64'd3);

        // Button held for 10 cycles gives exactly one pop
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
        check_all("held_button");
        chk("held_count_2", 64'(bus.count), 64'd2);
        chk("held_shows_22", 64'(bus.output_), 64'h22);
        cycle(1'b0, 32'h0, 1'b0);

        cycle(1'b0, 32'h0, 1'b1);
        check_all("pop_33");
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        check_all("pop_to_empty");
        chk("empty_output_zero", 64'(bus.output_), 64'h0);
        cycle(1'b0, 32'h0, 1'b0);

        // Pop request while empty is ignored
        cycle(1'b0, 32'h0, 1'b1);
        check_all("pop_when_empty");
        cycle(1'b0, 32'h0, 1'b0);

        // Fill to 16 (pointers start at 3, so wrap occurs)
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
        check_all("full_16");
        chk("full_flag", 64'(bus.full), 64'd1);

        // Full with simultaneous pop and write: accepted, no overflow
        cycle(1'b1, 32'hC0DE_0011, 1'b1);
        check_all("full_pop_write");
        chk("no_overflow_yet", 64'(bus.overflow), 64'd0);
        cycle(1'b0, 32'h0, 1'b0);

        // Write while full without pop is dropped and sets overflow
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        check_all("dropped_write");
        chk("overflow_set", 64'(bus.overflow), 64'd1);

        // Drain everything in order through the wrap
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check_all($sformatf("drain%0d", i));
            cycle(1'b0, 32'h0, 1'b0);
        end
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        // count==1 with simultaneous pop and write
        cycle(1'b1, 32'h0000_000A, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_000B, 1'b1);
        check_all("single_pop_write");
        chk("single_shows_B", 64'(bus.output_), 64'hB);
        cycle(1'b0, 32'h0, 1'b0);

        // Reset mid-operation takes effect before the next clock edge
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        chk("count_before_reset", 64'(bus.count), 64'd5);
        reset = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        check_all("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
